rgb_hue_fader: RTL and testbench

RGB_HUE_FADER -- requirements
Module: rgb_hue_fader

---
 rtl/rgb_hue_fader.sv | 116 +++++++++++
 tb/tb_rgb_hue_fader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rgb_hue_fader.sv
// Hue-cycling RGB LED driver: a prescaled ramp walks six hue sectors, either
// as solid colours or as a smooth fade, rendered through a shared PWM counter.
module rgb_hue_fader #(
  parameter int PWM_BITS      = 8,
  parameter int STEP_INTERVAL = 7812,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       mode,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic [2:0] sector
);

  localparam int                PRE_W    = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP_INTERVAL - 1);
  localparam logic [PWM_BITS-1:0] MAX    = '1;
  localparam logic              OFF      = (ACTIVE_LOW != 0);

  localparam logic [2:0] SEC_RED     = 3'd0;
  localparam logic [2:0] SEC_YELLOW  = 3'd1;
  localparam logic [2:0] SEC_GREEN   = 3'd2;
  localparam logic [2:0] SEC_CYAN    = 3'd3;
  localparam logic [2:0] SEC_BLUE    = 3'd4;
  localparam logic [2:0] SEC_MAGENTA = 3'd5;

  logic [PRE_W-1:0]              prescaler_q, prescaler_d;
  logic [PWM_BITS-1:0]           ramp_q, ramp_d;
  logic [PWM_BITS-1:0]           pwm_q, pwm_d;
  logic [2:0]                    sector_q, sector_d;
  logic [2:0][PWM_BITS-1:0]      duty_q, duty_d, duty_src;
  logic [2:0]                    rgb_q, rgb_d;
  logic                          tick;
  logic [PWM_BITS-1:0]           ramp_inv;

  always_comb begin
    tick        = enable && (prescaler_q == PRE_LAST);
    prescaler_d = prescaler_q;
    ramp_d      = ramp_q;
    sector_d    = sector_q;
    if (enable) begin
      prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    end
    if (tick) begin
      ramp_d = ramp_q + 1'b1;
      if (ramp_q == MAX) begin
        sector_d = (sector_q == SEC_MAGENTA) ? SEC_RED : sector_q + 3'd1;
      end
    end
    pwm_d = pwm_q + 1'b1;
  end

  // Duty triples indexed {B,G,R}; index 0 is red.
  always_comb begin
    ramp_inv = MAX - ramp_q;
    duty_src = '0;
    if (mode) begin
      case (sector_q)
        SEC_RED:     begin duty_src[0] = MAX;      duty_src[1] = ramp_q;   duty_src[2] = '0;       end
        SEC_YELLOW:  begin duty_src[0] = ramp_inv; duty_src[1] = MAX;      duty_src[2] = '0;       end
        SEC_GREEN:   begin duty_src[0] = '0;       duty_src[1] = MAX;      duty_src[2] = ramp_q;   end
        SEC_CYAN:    begin duty_src[0] = '0;       duty_src[1] = ramp_inv; duty_src[2] = MAX;      end
        SEC_BLUE:    begin duty_src[0] = ramp_q;   duty_src[1] = '0;       duty_src[2] = MAX;      end
        SEC_MAGENTA: begin duty_src[0] = MAX;      duty_src[1] = '0;       duty_src[2] = ramp_inv; end
        default:     duty_src = '0;
      endcase
    end else begin
      case (sector_q)
        SEC_RED:     begin duty_src[0] = MAX; duty_src[1] = '0;  duty_src[2] = '0;  end
        SEC_YELLOW:  begin duty_src[0] = MAX; duty_src[1] = MAX; duty_src[2] = '0;  end
        SEC_GREEN:   begin duty_src[0] = '0;  duty_src[1] = MAX; duty_src[2] = '0;  end
        SEC_CYAN:    begin duty_src[0] = '0;  duty_src[1] = MAX; duty_src[2] = MAX; end
        SEC_BLUE:    begin duty_src[0] = '0;  duty_src[1] = '0;  duty_src[2] = MAX; end
        SEC_MAGENTA: begin duty_src[0] = MAX; duty_src[1] = '0;  duty_src[2] = MAX; end
        default:     duty_src = '0;
      endcase
    end
    // Duties only move at the period boundary so no period is ever split.
    duty_d = (pwm_q == MAX) ? duty_src : duty_q;
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      always_comb begin
        rgb_d[gi] = ((duty_q[gi] > pwm_q) || (duty_q[gi] == MAX)) ^ OFF;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      ramp_q      <= '0;
      pwm_q       <= '0;
      sector_q    <= SEC_RED;
      duty_q      <= '0;
      rgb_q       <= {3{OFF}};
    end else begin
      prescaler_q <= prescaler_d;
      ramp_q      <= ramp_d;
      pwm_q       <= pwm_d;
      sector_q    <= sector_d;
      duty_q      <= duty_d;
      rgb_q       <= rgb_d;
    end
  end

  assign RGB_R  = rgb_q[0];
  assign RGB_G  = rgb_q[1];
  assign RGB_B  = rgb_q[2];
  assign sector = sector_q;

endmodule

// File: tb/tb_rgb_hue_fader.sv
// Bench for rgb_hue_fader (PWM_BITS=4, STEP_INTERVAL=2, active-low pins); the
// reference derives hue position from the count of enabled clocks.
module tb_rgb_hue_fader;

  localparam int PB  = 4;
  localparam int SI  = 2;
  localparam int MX  = 15;
  localparam int PER = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       mode = 1'b0;
  logic       RGB_R, RGB_G, RGB_B;
  logic [2:0] sector;

  int errors = 0;
  int checks = 0;

  int         en_cnt;
  int         cyc_cnt;
  int         duty_m [3];
  logic [2:0] exp_lvl;

  rgb_hue_fader #(.PWM_BITS(PB), .STEP_INTERVAL(SI), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B), .sector(sector)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input int expv);
    checks++;
    assert (obs === 8'(expv)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Hue table: duty of channel ch (0=R,1=G,2=B) for a sector/ramp/mode.
  function automatic int hue_duty(input int sec, input int r, input bit m, input int ch);
    int t [6][3];
    if (m) begin
      t[0] = '{MX, r, 0};      t[1] = '{MX - r, MX, 0}; t[2] = '{0, MX, r};
      t[3] = '{0, MX - r, MX}; t[4] = '{r, 0, MX};      t[5] = '{MX, 0, MX - r};
    end else begin
      t[0] = '{MX, 0, 0};  t[1] = '{MX, MX, 0}; t[2] = '{0, MX, 0};
      t[3] = '{0, MX, MX}; t[4] = '{0, 0, MX};  t[5] = '{MX, 0, MX};
    end
    return t[sec][ch];
  endfunction

  function automatic int model_sector();
    return (en_cnt / SI / PER) % 6;
  endfunction

  task automatic model_reset();
    en_cnt  = 0;
    cyc_cnt = 0;
    for (int c = 0; c < 3; c++) duty_m[c] = 0;
    exp_lvl = 3'b111;
  endtask

  // One clock: predict from pre-edge state, advance, then compare all outputs.
  task automatic step();
    int pwm_pre;
    int ticks;
    pwm_pre = cyc_cnt % PER;
    for (int c = 0; c < 3; c++) exp_lvl[c] = !((duty_m[c] > pwm_pre) || (duty_m[c] == MX));
    if (pwm_pre == MX) begin
      ticks = en_cnt / SI;
      for (int c = 0; c < 3; c++) duty_m[c] = hue_duty((ticks / PER) % 6, ticks % PER, mode, c);
    end
    if (enable) en_cnt++;
    cyc_cnt++;
    @(posedge clk);
    #1;
    chk("sector", {5'd0, sector}, model_sector());
    chk("rgb_r", {7'd0, RGB_R}, int'(exp_lvl[0]));
    chk("rgb_g", {7'd0, RGB_G}, int'(exp_lvl[1]));
    chk("rgb_b", {7'd0, RGB_B}, int'(exp_lvl[2]));
  endtask

  initial begin
    int lit_r, lit_g, lit_b;
    int seg_len;
    bit found;

    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_sector", {5'd0, sector}, 0);
    chk("reset_rgb", {5'd0, RGB_B, RGB_G, RGB_R}, 7);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Step mode, enabled: one full trip round the six sectors and back to red.
    mode = 1'b0;
    enable = 1'b1;
    repeat (200) step();

    // Fade mode until mid-cyan, then reset asynchronously between edges.
    mode = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (model_sector() == 3 && ((en_cnt / SI) % PER) == 7) found = 1'b1;
    end
    chk("reach_cyan", {7'd0, found}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_sector", {5'd0, sector}, 0);
    chk("midreset_rgb", {5'd0, RGB_B, RGB_G, RGB_R}, 7);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Fade, red sector, ramp parked at 5.
    mode = 1'b1;
    enable = 1'b1;
    repeat (10) step();
    enable = 1'b0;
    repeat (24) step();
    lit_r = 0; lit_g = 0; lit_b = 0;
    repeat (PER) begin
      step();
      lit_r += (RGB_R == 1'b0) ? 1 : 0;
      lit_g += (RGB_G == 1'b0) ? 1 : 0;
      lit_b += (RGB_B == 1'b0) ? 1 : 0;
    end
    chk("ramp5_lit_r", 8'(lit_r), 16);
    chk("ramp5_lit_g", 8'(lit_g), 5);
    chk("ramp5_lit_b", 8'(lit_b), 0);

    // Frozen hue for 200 clocks.
    repeat (200) step();

    // Random enable/mode segments of random length.
    for (int s = 0; s < 40; s++) begin
      enable  = ($urandom_range(0, 3) != 0);
      mode    = 1'($urandom_range(0, 1));
      seg_len = $urandom_range(1, 60);
      repeat (seg_len) step();
    end

    // Long enabled fade run across the magenta-to-red wrap.
    enable = 1'b1;
    mode = 1'b1;
    repeat (400) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
